psum_binarizer: RTL and testbench

Receiving end of the kernel's `psum_out` stream. It accumulates the 5-bit XNOR-popcount partial sums of one output pixel across `CHANNELS` input channels and binarizes the total against a programmable threshold. It then packs nine consecutive pixel bits into a 9-bit activation word in the same format `activation_in` uses on the next layer's kernel. It sits between the kernel array and the activation buffer of the following layer.

---
 rtl/psum_binarizer.sv | 123 ++++++++++++
 tb/tb_psum_binarizer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_binarizer.sv
// Accumulates kernel partial sums over CHANNELS beats per output pixel.
// Each pixel total is binarized against threshold_in. Nine pixel bits are
// packed into one activation word, handed downstream with valid/ready.
module psum_binarizer #(
  parameter int unsigned CHANNELS  = 16,
  parameter int unsigned ACC_WIDTH = 8
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 clear_in,
  input  logic                 psum_valid_in,
  input  logic [4:0]           psum_in,
  output logic                 psum_ready_out,
  input  logic [ACC_WIDTH-1:0] threshold_in,
  output logic                 act_valid_out,
  input  logic                 act_ready_in,
  output logic [8:0]           activation_out,
  output logic                 err_out
);

  localparam int unsigned      ChanW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [ChanW-1:0] LastChan = ChanW'(CHANNELS - 1);
  localparam logic [3:0]       LastPix  = 4'd8;
  localparam logic [4:0]       MaxPsum  = 5'd9;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ChanW-1:0]     chan_q, chan_d;
  logic [3:0]           pix_q, pix_d;
  logic [8:0]           pack_q, pack_d;
  logic                 act_valid_q, act_valid_d;
  logic [8:0]           act_q, act_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 illegal;
  logic [4:0]           psum_sat;
  logic [ACC_WIDTH:0]   acc_sum;
  logic                 pix_bit;
  logic [8:0]           pack_set;

  // Ready depends only on the output register, never on psum_valid_in.
  assign psum_ready_out = !act_valid_q || act_ready_in;
  assign act_valid_out  = act_valid_q;
  assign activation_out = act_q;
  assign err_out        = err_q;

  // Datapath: clamp, running sum, threshold compare and packed word with new bit.
  always_comb begin
    accept   = psum_valid_in && psum_ready_out;
    illegal  = psum_in > MaxPsum;
    psum_sat = illegal ? MaxPsum : psum_in;
    // One extra bit so the compare can never wrap.
    acc_sum  = {1'b0, acc_q} + (ACC_WIDTH + 1)'(psum_sat);
    pix_bit  = acc_sum >= {1'b0, threshold_in};
    pack_set = pack_q;
    pack_set[pix_q] = pix_bit;
  end

  // Next state for the pixel/word counters and the output register.
  always_comb begin
    acc_d       = acc_q;
    chan_d      = chan_q;
    pix_d       = pix_q;
    pack_d      = pack_q;
    act_valid_d = act_valid_q;
    act_d       = act_q;
    err_d       = err_q;

    if (act_valid_q && act_ready_in) begin
      act_valid_d = 1'b0;
    end

    if (clear_in) begin
      // A beat accepted alongside clear is dropped; the output word is kept.
      acc_d  = '0;
      chan_d = '0;
      pix_d  = '0;
      pack_d = '0;
    end else if (accept) begin
      if (illegal) begin
        err_d = 1'b1;
      end
      if (chan_q == LastChan) begin
        acc_d  = '0;
        chan_d = '0;
        if (pix_q == LastPix) begin
          pix_d       = '0;
          pack_d      = '0;
          act_d       = pack_set;
          act_valid_d = 1'b1;
        end else begin
          pix_d  = pix_q + 4'd1;
          pack_d = pack_set;
        end
      end else begin
        acc_d  = acc_sum[ACC_WIDTH-1:0];
        chan_d = chan_q + ChanW'(1);
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      acc_q       <= '0;
      chan_q      <= '0;
      pix_q       <= '0;
      pack_q      <= '0;
      act_valid_q <= 1'b0;
      act_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      chan_q      <= chan_d;
      pix_q       <= pix_d;
      pack_q      <= pack_d;
      act_valid_q <= act_valid_d;
      act_q       <= act_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_psum_binarizer.sv
// Self-checking bench for psum_binarizer: directed scenarios plus a random
// phase, all checked every cycle against a behavioural model of the stream.
module tb_psum_binarizer;

  localparam int CH = 16;

  logic       clk = 1'b0;
  logic       reset_in = 1'b1;
  logic       clear_in = 1'b0;
  logic       psum_valid_in = 1'b0;
  logic [4:0] psum_in = '0;
  logic       psum_ready_out;
  logic [7:0] threshold_in = 8'd72;
  logic       act_valid_out;
  logic       act_ready_in = 1'b1;
  logic [8:0] activation_out;
  logic       err_out;

  psum_binarizer #(.CHANNELS(CH), .ACC_WIDTH(8)) dut (
    .clk_in        (clk),
    .reset_in      (reset_in),
    .clear_in      (clear_in),
    .psum_valid_in (psum_valid_in),
    .psum_in       (psum_in),
    .psum_ready_out(psum_ready_out),
    .threshold_in  (threshold_in),
    .act_valid_out (act_valid_out),
    .act_ready_in  (act_ready_in),
    .activation_out(activation_out),
    .err_out       (err_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: pixel sums as plain integers, bits in an array.
  bit       m_valid = 0;
  bit [8:0] m_word  = '0;
  bit       m_err   = 0;
  int       m_sum   = 0;
  int       m_cnt   = 0;
  int       m_npix  = 0;
  bit [8:0] m_bits  = '0;
  int       m_beats = 0;
  int       m_words = 0;
  int       n_valid_cycles = 0;

  // Outputs are stable at the falling edge; inputs are stable until the next rise.
  always @(negedge clk) begin
    bit exp_ready;
    int v;
    if (reset_in) begin
      m_valid = 0; m_word = '0; m_err = 0;
      m_sum = 0; m_cnt = 0; m_npix = 0; m_bits = '0;
    end
    exp_ready = !m_valid || act_ready_in;
    check("psum_ready_out", psum_ready_out, exp_ready);
    check("act_valid_out", act_valid_out, m_valid);
    check("activation_out", activation_out, m_word);
    check("err_out", err_out, m_err);
    if (act_valid_out) n_valid_cycles++;
    if (!reset_in) begin
      if (m_valid && act_ready_in) m_valid = 0;
      if (clear_in) begin
        m_sum = 0; m_cnt = 0; m_npix = 0; m_bits = '0;
      end else if (psum_valid_in && exp_ready) begin
        v = (psum_in > 9) ? 9 : int'(psum_in);
        if (psum_in > 9) m_err = 1;
        m_sum += v;
        m_cnt++;
        m_beats++;
        if (m_cnt == CH) begin
          m_bits[m_npix] = (m_sum >= int'(threshold_in));
          m_sum = 0;
          m_cnt = 0;
          m_npix++;
          if (m_npix == 9) begin
            m_word = m_bits;
            m_valid = 1;
            m_bits = '0;
            m_npix = 0;
            m_words++;
          end
        end
      end
    end
  end

  // Present one beat and hold it until accepted; returns cycles spent.
  task automatic send(input logic [4:0] p, output int cycles);
    bit ok;
    cycles = 0;
    psum_valid_in = 1'b1;
    psum_in = p;
    forever begin
      @(negedge clk);
      ok = psum_ready_out;
      @(posedge clk);
      #1;
      cycles++;
      if (ok) break;
      if (cycles > 1000) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: beat not accepted after %0d cycles", cycles);
        break;
      end
    end
    psum_valid_in = 1'b0;
  endtask

  // Beat c of a pixel whose total is 72 (hi) or 71 (lo).
  function automatic logic [4:0] beat_val(input bit hi, input int c);
    if (c < 7) return 5'd9;
    if (c == 7) return hi ? 5'd9 : 5'd8;
    return 5'd0;
  endfunction

  task automatic send_word_pattern(input logic [8:0] pat);
    int cy;
    for (int p = 0; p < 9; p++)
      for (int c = 0; c < CH; c++) send(beat_val(pat[p], c), cy);
  endtask

  task automatic send_const(input logic [4:0] v, input int n);
    int cy;
    for (int i = 0; i < n; i++) send(v, cy);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cy;
    int total;
    int base_beats;
    int base_words;
    int base_vc;
    logic [8:0] pat;

    repeat (3) @(posedge clk);
    #1 reset_in = 1'b0;

    // Threshold boundary: 72/71 alternating, bit set only at >= threshold.
    threshold_in = 8'd72;
    act_ready_in = 1'b1;
    pat = 9'h155;
    for (int p = 0; p < 9; p++)
      for (int c = 0; c < CH; c++) begin
        if (p == 8 && c == CH - 1) check("thr_not_early", act_valid_out, 1'b0);
        send(beat_val(pat[p], c), cy);
      end
    check("thr_valid", act_valid_out, 1'b1);
    check("thr_word", activation_out, 9'b1_0101_0101);
    tick();

    // Saturation: a single 12 among zeros clamps to 9 and meets threshold 9.
    threshold_in = 8'd9;
    for (int c = 0; c < CH; c++) send((c == 5) ? 5'd12 : 5'd0, cy);
    send_const(5'd0, 8 * CH);
    check("sat_word", activation_out, 9'h001);
    check("sat_err", err_out, 1'b1);
    tick();

    // Backpressure: word held, ready low, then released in the same cycle.
    threshold_in = 8'd72;
    act_ready_in = 1'b0;
    send_const(5'd9, 9 * CH);
    psum_valid_in = 1'b1;
    psum_in = 5'd9;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_ready_low", psum_ready_out, 1'b0);
      check("bp_word_held", activation_out, 9'h1FF);
    end
    @(posedge clk);
    #1 act_ready_in = 1'b1;
    #1 check("bp_ready_back", psum_ready_out, 1'b1);
    send(5'd9, cy);
    check("bp_first_beat_cycles", cy, 1);
    send_const(5'd9, 9 * CH - 1);
    check("bp_word2", activation_out, 9'h1FF);
    check("err_sticky", err_out, 1'b1);
    tick();

    // Clear at pix 4 / chan 7 with a valid beat: the next word needs 144 fresh beats.
    send_const(5'd0, 4 * CH + 7);
    clear_in = 1'b1;
    psum_valid_in = 1'b1;
    psum_in = 5'd9;
    tick();
    clear_in = 1'b0;
    psum_valid_in = 1'b0;
    pat = 9'b0_0110_1011;
    base_beats = m_beats;
    send_word_pattern(pat);
    check("clr_word", activation_out, 9'b0_0110_1011);
    check("clr_beats", m_beats - base_beats, 144);
    tick();

    // Pending undrained word survives clear.
    act_ready_in = 1'b0;
    send_const(5'd9, 9 * CH);
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    check("clr_pending_valid", act_valid_out, 1'b1);
    check("clr_pending_word", activation_out, 9'h1FF);
    act_ready_in = 1'b1;
    tick();

    // Streaming: three words back to back, no ready gaps.
    base_beats = m_beats;
    base_words = m_words;
    base_vc = n_valid_cycles;
    total = 0;
    for (int w = 0; w < 3; w++) begin
      threshold_in = 8'($urandom_range(0, 144));
      for (int i = 0; i < 9 * CH; i++) begin
        send(5'($urandom_range(0, 9)), cy);
        total += cy;
      end
    end
    tick();
    check("stream_cycles", total, 432);
    check("stream_beats", m_beats - base_beats, 432);
    check("stream_words", m_words - base_words, 3);
    check("stream_valid_pulses", n_valid_cycles - base_vc, 3);

    // Random phase.
    for (int i = 0; i < 4000; i++) begin
      psum_valid_in = ($urandom_range(0, 3) != 0);
      clear_in = ($urandom_range(0, 80) == 0);
      if (!clear_in && $urandom_range(0, 40) == 0) psum_in = 5'($urandom_range(10, 31));
      else psum_in = 5'($urandom_range(0, 9));
      act_ready_in = ($urandom_range(0, 3) != 0);
      threshold_in = 8'($urandom_range(0, 144));
      reset_in = ($urandom_range(0, 500) == 0);
      tick();
    end
    reset_in = 1'b0;
    clear_in = 1'b0;
    psum_valid_in = 1'b0;
    act_ready_in = 1'b1;
    tick();
    tick();

    // Reset mid-pixel (pix 3, chan 5) after an illegal beat.
    threshold_in = 8'd72;
    send(5'd15, cy);
    send_const(5'd9, 3 * CH + 4);
    check("pre_reset_err", err_out, 1'b1);
    reset_in = 1'b1;
    #1;
    check("rst_valid", act_valid_out, 1'b0);
    check("rst_word", activation_out, 9'h000);
    check("rst_err", err_out, 1'b0);
    check("rst_ready", psum_ready_out, 1'b1);
    tick();
    reset_in = 1'b0;
    send_const(5'd9, 9 * CH);
    check("post_rst_valid", act_valid_out, 1'b1);
    check("post_rst_word", activation_out, 9'h1FF);
    check("post_rst_err", err_out, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
